// File: rtl/tt_nor_xor_descrambler.sv
// Strobe-driven loader and bit-serial inverse of the NOR-XOR scrambler.
// Low nibble, then high nibble, then eight decode cycles.
module tt_nor_xor_descrambler (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HI   = 2'd1;
  localparam logic [1:0] DEC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic       clk;
  logic       rst;
  logic       stb;
  logic       view;
  logic [3:0] nib;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign stb  = io_in[2];
  assign view = io_in[3];
  assign nib  = io_in[7:4];

  logic [1:0] state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [7:0] w_q, w_d;
  logic [7:0] res_q, res_d;
  logic [2:0] step_q, step_d;
  logic [2:0] cnt_q, cnt_d;
  logic       s1_q, s2_q;
  logic       edge_s;
  logic       bit_s;
  logic [2:0] pos_s;

  assign edge_s = s1_q & ~s2_q;

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // Later steps consume d bits already resolved into w_q.
  always_comb begin
    bit_s = 1'b0;
    pos_s = 3'd0;
    unique case (step_q)
      3'd0: begin pos_s = 3'd3; bit_s = y_q[4] ^ nor2(y_q[7], y_q[6]); end
      3'd1: begin pos_s = 3'd7; bit_s = y_q[1] ^ nor2(y_q[2], y_q[7]); end
      3'd2: begin pos_s = 3'd5; bit_s = y_q[7] ^ nor2(y_q[6], y_q[5]); end
      3'd3: begin pos_s = 3'd1; bit_s = y_q[3] ^ nor2(y_q[5], w_q[3]); end
      3'd4: begin pos_s = 3'd2; bit_s = y_q[0] ^ nor2(y_q[3], y_q[1]); end
      3'd5: begin pos_s = 3'd0; bit_s = y_q[5] ^ nor2(w_q[3], w_q[2]); end
      3'd6: begin pos_s = 3'd6; bit_s = y_q[2] ^ nor2(w_q[2], w_q[1]); end
      3'd7: begin pos_s = 3'd4; bit_s = y_q[6] ^ nor2(w_q[7], w_q[6]); end
      default: begin pos_s = 3'd0; bit_s = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    w_d     = w_q;
    res_d   = res_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE),
      (state_q == DONE): begin
        if (edge_s) begin
          y_d[3:0] = nib;
          step_d   = 3'd0;
          state_d  = HI;
        end
      end
      (state_q == HI): begin
        if (edge_s) begin
          y_d[7:4] = nib;
          w_d      = 8'h00;
          step_d   = 3'd0;
          state_d  = DEC;
        end
      end
      (state_q == DEC): begin
        w_d[pos_s] = bit_s;
        if (step_q == 3'd7) begin
          res_d   = w_d;
          cnt_d   = cnt_q + 3'd1;
          state_d = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 8'h00;
      w_q     <= 8'h00;
      res_q   <= 8'h00;
      step_q  <= 3'd0;
      cnt_q   <= 3'd0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      w_q     <= w_d;
      res_q   <= res_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      s1_q    <= stb;
      s2_q    <= s1_q;
    end
  end

  assign io_out = view ? {state_q, step_q, cnt_q} : res_q;

endmodule

// File: tb/tb_tt_nor_xor_descrambler.sv
// Directed and randomized bench for tt_nor_xor_descrambler.
// Expected bytes come from a word-level inverse-scrambler model.
module tb_tt_nor_xor_descrambler;

  logic       clk;
  logic       rst;
  logic       stb;
  logic       view;
  logic [3:0] nib;
  logic [7:0] io_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] res_m;
  logic [2:0] cnt_m;

  tt_nor_xor_descrambler dut (
    .io_in  ({nib, view, stb, rst, clk}),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_dec(input logic [7:0] y);
    logic [7:0] d;
    d[3] = y[4] ^ !(y[7] | y[6]);
    d[7] = y[1] ^ !(y[2] | y[7]);
    d[5] = y[7] ^ !(y[6] | y[5]);
    d[1] = y[3] ^ !(y[5] | d[3]);
    d[2] = y[0] ^ !(y[3] | y[1]);
    d[0] = y[5] ^ !(d[3] | d[2]);
    d[6] = y[2] ^ !(d[2] | d[1]);
    d[4] = y[6] ^ !(d[7] | d[6]);
    return d;
  endfunction

  function automatic logic [7:0] stat(
    input logic [1:0] s, input logic [2:0] st, input logic [2:0] c);
    return {s, st, c};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic v, output logic [7:0] o);
    view = v;
    #1;
    o = io_out;
  endtask

  task automatic pulse(input logic [3:0] n);
    @(negedge clk);
    nib = n;
    stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    res_m = 8'h00;
    cnt_m = 3'd0;
  endtask

  task automatic decode(input logic [7:0] y);
    pulse(y[3:0]);
    pulse(y[7:4]);
    repeat (8) @(negedge clk);
    res_m = ref_dec(y);
    cnt_m = cnt_m + 3'd1;
  endtask

  task automatic chk_done(input string tag);
    logic [7:0] o;
    rd(1'b0, o);
    chk({tag, "_res"}, o, res_m);
    rd(1'b1, o);
    chk({tag, "_stat"}, o, stat(2'd3, 3'd7, cnt_m));
  endtask

  initial begin
    logic [7:0] o;
    logic [7:0] prev;
    logic [7:0] y;
    rst = 1'b1; stb = 1'b0; view = 1'b0; nib = 4'h0;
    res_m = 8'h00; cnt_m = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(1'b0, o); chk("rst_v0", o, 8'h00);
    rd(1'b1, o); chk("rst_v1", o, 8'h00);

    decode(8'h65);
    chk_done("y65");
    rd(1'b1, o); chk("y65_F9", o, 8'hF9);

    // Result must hold until exactly C+8.
    prev = res_m;
    pulse(4'h3);
    pulse(4'hA);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        rd(1'b0, o); chk("lat_hold", o, prev);
        rd(1'b1, o); chk("lat_stat", o, stat(2'd2, i[2:0], cnt_m));
      end
    end
    res_m = ref_dec(8'hA3);
    cnt_m = cnt_m + 3'd1;
    rd(1'b0, o); chk("lat_A5", o, 8'hA5);
    chk_done("yA3");

    do_reset();
    for (int k = 0; k < 9; k++) decode(8'hFF);
    chk_done("wrap");
    rd(1'b0, o); chk("wrap_FF", o, 8'hFF);
    rd(1'b1, o); chk("wrap_low", {5'd0, o[2:0]}, 8'h01);

    prev = res_m;
    pulse(4'h9);
    pulse(4'h4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      stb = (i < 6) ? i[0] : 1'b0;
      nib = 4'(i);
      if (i < 8) begin
        rd(1'b0, o); chk("tog_hold", o, prev);
        rd(1'b1, o); chk("tog_state", {6'd0, o[7:6]}, 8'd2);
      end
    end
    res_m = ref_dec(8'h49);
    cnt_m = cnt_m + 3'd1;
    chk_done("tog");
    pulse(4'hC);
    @(negedge clk);
    rd(1'b1, o); chk("tog_hi", o, stat(2'd1, 3'd0, cnt_m));
    rd(1'b0, o); chk("tog_keep", o, res_m);
    pulse(4'h7);
    repeat (8) @(negedge clk);
    res_m = ref_dec(8'h7C);
    cnt_m = cnt_m + 3'd1;
    chk_done("tog2");

    pulse(4'h5);
    pulse(4'h6);
    repeat (4) @(negedge clk);
    rd(1'b1, o); chk("mid_step4", o, stat(2'd2, 3'd4, cnt_m));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    res_m = 8'h00;
    cnt_m = 3'd0;
    rd(1'b0, o); chk("mid_rst_v0", o, 8'h00);
    rd(1'b1, o); chk("mid_rst_v1", o, 8'h00);
    decode(8'h65);
    chk_done("mid_re65");

    // Long strobe: a second edge would corrupt the capture.
    y = 8'(($urandom & 32'hFF));
    @(negedge clk);
    nib = y[3:0];
    stb = 1'b1;
    repeat (3) @(negedge clk);
    nib = ~y[3:0];
    repeat (17) @(negedge clk);
    stb = 1'b0;
    repeat (3) @(negedge clk);
    rd(1'b1, o); chk("hold_hi", o, stat(2'd1, 3'd0, cnt_m));
    pulse(y[7:4]);
    repeat (8) @(negedge clk);
    res_m = ref_dec(y);
    cnt_m = cnt_m + 3'd1;
    chk_done("hold");

    for (int k = 0; k < 24; k++) begin
      y = 8'(($urandom & 32'hFF));
      decode(y);
      chk_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_nor_xor_descrambler.md
TT_NOR_XOR_DESCRAMBLER -- requirements
Module: tt_nor_xor_descrambler

Interface
- REQ-001: The block SHALL have no parameters.
- REQ-002: io_in[0]  input  1  clk: the single clock; all state SHALL update on its rising edge.
- REQ-003: io_in[1]  input  1  rst: synchronous, active-high reset.
- REQ-004: io_in[2]  input  1  stb: nibble-load strobe, asynchronous to clk, for example a manual switch.
- REQ-005: io_in[3]  input  1  view: output select; 0 selects the decoded byte, 1 selects the status byte.
- REQ-006: io_in[7:4]  input  4  nib: scrambled-word nibble; it SHALL be held stable from the strobe rising edge until the nibble is captured.
- REQ-007: io_out[7:0]  output  8  the decoded byte (view=0) or the status byte (view=1).

Function
- REQ-008: The block SHALL invert the NOR-XOR scrambler. Scrambled word y[7:0] maps to plain byte d[7:0], where nor(a,b) means ~(a|b).
- REQ-009: stb SHALL be registered once (s1) and again (s2); an edge SHALL be detected in any cycle where s1=1 and s2=0.
- REQ-010: The FSM SHALL have four states with fixed codes: IDLE=0, HI=1, DEC=2, DONE=3.
- REQ-011: When an edge is detected in IDLE or DONE, the block SHALL capture nib into y[3:0], clear step to 0, and move to HI.
- REQ-012: When an edge is detected in HI, the block SHALL capture nib into y[7:4] and move to DEC with step=0.
- REQ-013: Edges detected in DEC SHALL be ignored; they SHALL NOT be queued. s1 and s2 SHALL keep updating.
- REQ-014: In DEC, the block SHALL resolve one bit per cycle into a working register w, which is cleared on entry to DEC. Order by step, 0 to 7:
  - step 0: d3 = y4 ^ nor(y7,y6)
  - step 1: d7 = y1 ^ nor(y2,y7)
  - step 2: d5 = y7 ^ nor(y6,y5)
  - step 3: d1 = y3 ^ nor(y5,d3)
  - step 4: d2 = y0 ^ nor(y3,y1)
  - step 5: d0 = y5 ^ nor(d3,d2)
  - step 6: d6 = y2 ^ nor(d2,d1)
  - step 7: d4 = y6 ^ nor(d7,d6)
- REQ-015: Steps that depend on d terms SHALL read the values resolved into w by earlier steps.
- REQ-016: At the clock edge that completes step 7, the block SHALL:
  - copy the completed byte into result,
  - increment cnt[2:0], wrapping 7 -> 0,
  - move to DONE, holding step at 7.
- REQ-017: Latency: if the high nibble is captured at edge C, result and DONE SHALL be valid after edge C+8.
- REQ-018: result SHALL change only at decode completion; partial w values SHALL never appear on io_out.
- REQ-019: The status byte SHALL be {state[1:0], step[2:0], cnt[2:0]}.
- REQ-020: io_out SHALL be a combinational mux of registered values selected by view; changing view SHALL take effect in the same cycle.
- REQ-021: If an edge is detected in DONE, the block SHALL start a new load (REQ-011) while result keeps showing the previous decode until the next completion.

Reset
- REQ-022: When rst=1 at a clock edge, the block SHALL set state=IDLE and clear y, w, result, step, cnt, s1 and s2 to 0.
- REQ-023: Reset SHALL take priority over every event, including mid-DEC and same-cycle strobe edges.
- REQ-024: After reset, io_out SHALL be 0x00 in both views.

Verification
- REQ-025: Reset, then load nibbles 0x5 and then 0x6 (y=0x65) -> after 8 DEC cycles, view=0 shows 0x00 and view=1 shows 0xF9 (state 3, step 7, cnt 1).
- REQ-026: Load y=0xA3 -> result 0xA5 exactly at edge C+8; result SHALL hold its previous value during edges C+1..C+7.
- REQ-027: Load y=0xFF -> result 0xFF; nine back-to-back decodes -> cnt wraps to 1 and the status low bits read 0b001.
- REQ-028: Toggle stb repeatedly during DEC -> result unaffected and state still IDLE/HI-free; after DONE, the next edge captures the low nibble and the status shows state=1.
- REQ-029: Assert rst at step 4 of DEC, then deassert -> io_out=0x00 in both views and state=IDLE; a fresh load of 0x65 then decodes to 0x00.
- REQ-030: Hold stb high for 20 cycles -> exactly one edge is recognised and exactly one nibble is captured.
